// File: rtl/id_issue_stage.sv
// id_issue_stage: dual-issue decision for the two instruction-queue heads plus the ID/EX
// pipeline registers. It also has a small FSM for branch delay slots and for serialising
// privileged instructions.
module id_issue_stage #(
    parameter int unsigned CP_W = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                SBA_flush_w_i,
    input  logic                CP0_excOccur_w_i,
    input  logic [1:0]          IQ_supplyValid,
    input  logic [63:0]         IQ_inst_p,
    input  logic [63:0]         IQ_VAddr_p,
    input  logic [63:0]         IQ_predDest_p,
    input  logic [1:0]          IQ_hasException_p,
    input  logic [1:0]          IQ_isRefill_p,
    input  logic [1:0]          IQ_predTake_p,
    input  logic [9:0]          IQ_ExcCode_p,
    input  logic [2*CP_W-1:0]   IQ_checkPoint_p,
    input  logic [1:0]          DEC_wen_p,
    input  logic [9:0]          DEC_wdst_p,
    input  logic [3:0]          DEC_ren_p,
    input  logic [19:0]         DEC_rsrc_p,
    input  logic [1:0]          DEC_isBranch_p,
    input  logic [1:0]          DEC_isPriv_p,
    input  logic [1:0]          DEC_isMulDiv_p,
    input  logic                EX_ready_i,
    input  logic                WB_privDone_i,
    output logic [1:0]          ID_upDateMode_o,
    output logic [1:0]          ID_valid_o,
    output logic [63:0]         ID_inst_p,
    output logic [63:0]         ID_VAddr_p,
    output logic [63:0]         ID_predDest_p,
    output logic [1:0]          ID_hasException_p,
    output logic [9:0]          ID_ExcCode_p,
    output logic [1:0]          ID_isRefill_p,
    output logic [1:0]          ID_predTake_p,
    output logic [2*CP_W-1:0]   ID_checkPoint_p,
    output logic [1:0]          ID_isDelaySlot_o
);

    localparam int unsigned XW = 32;
    localparam int unsigned RW = 5;

    typedef enum logic [1:0] {
        S_NORMAL  = 2'd0,
        S_WAIT_DS = 2'd1,
        S_SERIAL  = 2'd2
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic          w_flush;
    logic          w_can_issue;
    logic          w_hazard;
    logic          w_issue0;
    logic          w_issue1;
    logic [RW-1:0] w_wdst0;
    logic [RW-1:0] w_wdst1;
    logic [RW-1:0] w_rs1;
    logic [RW-1:0] w_rt1;

    // Slot0 source operands never conflict with anything inside the pair.
    logic w_unused_ok;
    assign w_unused_ok = &{1'b0, DEC_ren_p[1:0], DEC_rsrc_p[9:0]};

    assign w_wdst0 = DEC_wdst_p[RW-1:0];
    assign w_wdst1 = DEC_wdst_p[2*RW-1:RW];
    assign w_rs1   = DEC_rsrc_p[3*RW-1:2*RW];
    assign w_rt1   = DEC_rsrc_p[4*RW-1:3*RW];

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_NORMAL;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic. A flush overrides every other event.
    always_comb begin
        w_state_nxt = r_state;
        if (w_flush) begin
            w_state_nxt = S_NORMAL;
        end else begin
            case (r_state)
                S_NORMAL: begin
                    if (w_issue0) begin
                        if (DEC_isPriv_p[0]) begin
                            w_state_nxt = S_SERIAL;
                        end else if (DEC_isBranch_p[0] && !w_issue1) begin
                            w_state_nxt = S_WAIT_DS;
                        end
                    end
                end
                S_WAIT_DS: begin
                    if (w_issue0) begin
                        w_state_nxt = DEC_isPriv_p[0] ? S_SERIAL : S_NORMAL;
                    end
                end
                S_SERIAL: begin
                    if (WB_privDone_i) begin
                        w_state_nxt = S_NORMAL;
                    end
                end
                default: w_state_nxt = S_NORMAL;
            endcase
        end
    end

    // Issue decision and the dequeue count returned to the queue.
    always_comb begin
        w_flush     = SBA_flush_w_i | CP0_excOccur_w_i;
        w_can_issue = !rst && EX_ready_i && !w_flush && (r_state != S_SERIAL);
        w_hazard    = 1'b0;
        if (DEC_wen_p[0] && (w_wdst0 != '0) &&
            ((DEC_ren_p[2] && (w_rs1 == w_wdst0)) || (DEC_ren_p[3] && (w_rt1 == w_wdst0)))) begin
            w_hazard = 1'b1;
        end
        if (DEC_wen_p[0] && DEC_wen_p[1] && (w_wdst0 != '0) && (w_wdst0 == w_wdst1)) begin
            w_hazard = 1'b1;
        end
        if ((&DEC_isMulDiv_p) || (|DEC_isPriv_p) || IQ_hasException_p[0] || DEC_isBranch_p[1]) begin
            w_hazard = 1'b1;
        end
        w_issue0        = w_can_issue & IQ_supplyValid[0];
        w_issue1        = w_issue0 & IQ_supplyValid[1] & !w_hazard;
        ID_upDateMode_o = {w_issue1, w_issue0};
    end

    // ID/EX pipeline registers. A slot that was not issued is loaded as zero.
    always_ff @(posedge clk) begin
        if (rst || w_flush) begin
            ID_valid_o        <= '0;
            ID_isDelaySlot_o  <= '0;
            ID_inst_p         <= '0;
            ID_VAddr_p        <= '0;
            ID_predDest_p     <= '0;
            ID_hasException_p <= '0;
            ID_ExcCode_p      <= '0;
            ID_isRefill_p     <= '0;
            ID_predTake_p     <= '0;
            ID_checkPoint_p   <= '0;
        end else if (EX_ready_i) begin
            ID_valid_o        <= {w_issue1, w_issue0};
            ID_isDelaySlot_o  <= {w_issue1 & DEC_isBranch_p[0], w_issue0 & (r_state == S_WAIT_DS)};
            ID_inst_p         <= IQ_inst_p     & {{XW{w_issue1}}, {XW{w_issue0}}};
            ID_VAddr_p        <= IQ_VAddr_p    & {{XW{w_issue1}}, {XW{w_issue0}}};
            ID_predDest_p     <= IQ_predDest_p & {{XW{w_issue1}}, {XW{w_issue0}}};
            ID_hasException_p <= IQ_hasException_p & {w_issue1, w_issue0};
            ID_ExcCode_p      <= IQ_ExcCode_p  & {{RW{w_issue1}}, {RW{w_issue0}}};
            ID_isRefill_p     <= IQ_isRefill_p & {w_issue1, w_issue0};
            ID_predTake_p     <= IQ_predTake_p & {w_issue1, w_issue0};
            ID_checkPoint_p   <= IQ_checkPoint_p & {{CP_W{w_issue1}}, {CP_W{w_issue0}}};
        end
    end

endmodule

// File: tb/tb_id_issue_stage.sv
// Bench for id_issue_stage: directed scenarios followed by random traffic, all checked
// against a behavioural issue model.
module tb_id_issue_stage;

    localparam int CP_W = 32;
    localparam int PW   = 272;

    logic              clk = 1'b0;
    logic              rst;
    logic              SBA_flush_w_i, CP0_excOccur_w_i;
    logic [1:0]        IQ_supplyValid;
    logic [63:0]       IQ_inst_p, IQ_VAddr_p, IQ_predDest_p;
    logic [1:0]        IQ_hasException_p, IQ_isRefill_p, IQ_predTake_p;
    logic [9:0]        IQ_ExcCode_p;
    logic [2*CP_W-1:0] IQ_checkPoint_p;
    logic [1:0]        DEC_wen_p;
    logic [9:0]        DEC_wdst_p;
    logic [3:0]        DEC_ren_p;
    logic [19:0]       DEC_rsrc_p;
    logic [1:0]        DEC_isBranch_p, DEC_isPriv_p, DEC_isMulDiv_p;
    logic              EX_ready_i, WB_privDone_i;
    logic [1:0]        ID_upDateMode_o, ID_valid_o;
    logic [63:0]       ID_inst_p, ID_VAddr_p, ID_predDest_p;
    logic [1:0]        ID_hasException_p, ID_isRefill_p, ID_predTake_p;
    logic [9:0]        ID_ExcCode_p;
    logic [2*CP_W-1:0] ID_checkPoint_p;
    logic [1:0]        ID_isDelaySlot_o;

    id_issue_stage #(.CP_W(CP_W)) dut (
        .clk(clk), .rst(rst),
        .SBA_flush_w_i(SBA_flush_w_i), .CP0_excOccur_w_i(CP0_excOccur_w_i),
        .IQ_supplyValid(IQ_supplyValid),
        .IQ_inst_p(IQ_inst_p), .IQ_VAddr_p(IQ_VAddr_p), .IQ_predDest_p(IQ_predDest_p),
        .IQ_hasException_p(IQ_hasException_p), .IQ_isRefill_p(IQ_isRefill_p),
        .IQ_predTake_p(IQ_predTake_p), .IQ_ExcCode_p(IQ_ExcCode_p),
        .IQ_checkPoint_p(IQ_checkPoint_p),
        .DEC_wen_p(DEC_wen_p), .DEC_wdst_p(DEC_wdst_p), .DEC_ren_p(DEC_ren_p),
        .DEC_rsrc_p(DEC_rsrc_p), .DEC_isBranch_p(DEC_isBranch_p),
        .DEC_isPriv_p(DEC_isPriv_p), .DEC_isMulDiv_p(DEC_isMulDiv_p),
        .EX_ready_i(EX_ready_i), .WB_privDone_i(WB_privDone_i),
        .ID_upDateMode_o(ID_upDateMode_o), .ID_valid_o(ID_valid_o),
        .ID_inst_p(ID_inst_p), .ID_VAddr_p(ID_VAddr_p), .ID_predDest_p(ID_predDest_p),
        .ID_hasException_p(ID_hasException_p), .ID_ExcCode_p(ID_ExcCode_p),
        .ID_isRefill_p(ID_isRefill_p), .ID_predTake_p(ID_predTake_p),
        .ID_checkPoint_p(ID_checkPoint_p), .ID_isDelaySlot_o(ID_isDelaySlot_o)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: 0 = normal, 1 = waiting for delay slot, 2 = serialised.
    int            m_state;
    logic [1:0]    m_valid;
    logic [1:0]    m_ds;
    logic [PW-1:0] m_pay;

    task automatic chk(input string tag, input logic [PW-1:0] obs, input logic [PW-1:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [PW-1:0] dut_pay();
        return {ID_inst_p, ID_VAddr_p, ID_predDest_p, ID_hasException_p, ID_ExcCode_p,
                ID_isRefill_p, ID_predTake_p, ID_checkPoint_p};
    endfunction

    // How many heads the rules allow to leave the queue this cycle.
    task automatic model_decide(output bit i0, output bit i1);
        bit flush, can, haz;
        int wd0, wd1, rs1, rt1;
        wd0 = int'(DEC_wdst_p[4:0]);   wd1 = int'(DEC_wdst_p[9:5]);
        rs1 = int'(DEC_rsrc_p[14:10]); rt1 = int'(DEC_rsrc_p[19:15]);
        flush = SBA_flush_w_i || CP0_excOccur_w_i;
        can   = !rst && EX_ready_i && !flush && (m_state != 2);
        haz   = 1'b0;
        if (DEC_wen_p[0] && wd0 != 0 && ((DEC_ren_p[2] && rs1 == wd0) || (DEC_ren_p[3] && rt1 == wd0))) haz = 1'b1;
        if (DEC_wen_p == 2'b11 && wd0 != 0 && wd0 == wd1) haz = 1'b1;
        if (DEC_isMulDiv_p == 2'b11 || DEC_isPriv_p != 2'b00) haz = 1'b1;
        if (IQ_hasException_p[0] || DEC_isBranch_p[1]) haz = 1'b1;
        i0 = can && IQ_supplyValid[0];
        i1 = i0 && IQ_supplyValid[1] && !haz;
    endtask

    function automatic logic [PW-1:0] issued_pay(bit i0, bit i1);
        logic [PW-1:0] lo, hi;
        lo = {32'd0, IQ_inst_p[31:0], 32'd0, IQ_VAddr_p[31:0], 32'd0, IQ_predDest_p[31:0],
              1'b0, IQ_hasException_p[0], 5'd0, IQ_ExcCode_p[4:0], 1'b0, IQ_isRefill_p[0],
              1'b0, IQ_predTake_p[0], 32'd0, IQ_checkPoint_p[31:0]};
        hi = {IQ_inst_p[63:32], 32'd0, IQ_VAddr_p[63:32], 32'd0, IQ_predDest_p[63:32], 32'd0,
              IQ_hasException_p[1], 1'b0, IQ_ExcCode_p[9:5], 5'd0, IQ_isRefill_p[1], 1'b0,
              IQ_predTake_p[1], 1'b0, IQ_checkPoint_p[63:32], 32'd0};
        return (i0 ? lo : '0) | (i1 ? hi : '0);
    endfunction

    // One clock: check the combinational count, advance the model, check the registers.
    task automatic step();
        bit i0, i1, flush;
        int ns;
        logic [1:0] nv, nd;
        logic [PW-1:0] np;
        #1;
        model_decide(i0, i1);
        chk("upDateMode", PW'(ID_upDateMode_o), PW'({i1, i0}));
        flush = SBA_flush_w_i || CP0_excOccur_w_i;
        nv = m_valid; nd = m_ds; np = m_pay; ns = m_state;
        if (rst || flush) begin
            nv = 2'b00; nd = 2'b00; np = '0; ns = 0;
        end else begin
            if (EX_ready_i) begin
                nv = {i1, i0};
                nd = {i1 && DEC_isBranch_p[0], i0 && m_state == 1};
                np = issued_pay(i0, i1);
            end
            if (m_state == 2) begin
                if (WB_privDone_i) ns = 0;
            end else if (i0) begin
                if (DEC_isPriv_p[0]) ns = 2;
                else if (m_state == 0 && DEC_isBranch_p[0] && !i1) ns = 1;
                else ns = 0;
            end
        end
        @(posedge clk);
        #1;
        m_valid = nv; m_ds = nd; m_pay = np; m_state = ns;
        chk("valid", PW'(ID_valid_o), PW'(m_valid));
        chk("delayslot", PW'(ID_isDelaySlot_o), PW'(m_ds));
        chk("payload", dut_pay(), m_pay);
        @(negedge clk);
    endtask

    task automatic clear_in();
        rst = 1'b0; SBA_flush_w_i = 1'b0; CP0_excOccur_w_i = 1'b0; IQ_supplyValid = 2'b00;
        IQ_inst_p = 64'h0000_0021_0000_0020; IQ_VAddr_p = 64'h8000_0004_8000_0000;
        IQ_predDest_p = '0; IQ_hasException_p = '0; IQ_isRefill_p = '0; IQ_predTake_p = '0;
        IQ_ExcCode_p = '0; IQ_checkPoint_p = 64'h0000_0002_0000_0001;
        DEC_wen_p = '0; DEC_wdst_p = '0; DEC_ren_p = '0; DEC_rsrc_p = '0;
        DEC_isBranch_p = '0; DEC_isPriv_p = '0; DEC_isMulDiv_p = '0;
        EX_ready_i = 1'b1; WB_privDone_i = 1'b0;
    endtask

    task automatic rand_in();
        int k;
        rst = ($urandom_range(0, 49) == 0);
        SBA_flush_w_i = ($urandom_range(0, 24) == 0);
        CP0_excOccur_w_i = ($urandom_range(0, 39) == 0);
        k = $urandom_range(0, 3);
        IQ_supplyValid = (k == 0) ? 2'b00 : (k == 1) ? 2'b01 : 2'b11;
        IQ_inst_p = {$urandom, $urandom}; IQ_VAddr_p = {$urandom, $urandom};
        IQ_predDest_p = {$urandom, $urandom}; IQ_checkPoint_p = {$urandom, $urandom};
        IQ_hasException_p = {1'b0, ($urandom_range(0, 9) == 0)} | 2'($urandom_range(0, 3) & 2);
        IQ_isRefill_p = 2'($urandom); IQ_predTake_p = 2'($urandom); IQ_ExcCode_p = 10'($urandom);
        DEC_wen_p = 2'($urandom);
        DEC_wdst_p = {5'($urandom_range(0, 5)), 5'($urandom_range(0, 5))};
        DEC_ren_p = 4'($urandom);
        DEC_rsrc_p = {5'($urandom_range(0, 5)), 5'($urandom_range(0, 5)), 10'($urandom)};
        DEC_isBranch_p = {($urandom_range(0, 5) == 0), ($urandom_range(0, 3) == 0)};
        DEC_isPriv_p = {($urandom_range(0, 11) == 0), ($urandom_range(0, 9) == 0)};
        DEC_isMulDiv_p = {($urandom_range(0, 2) == 0), ($urandom_range(0, 2) == 0)};
        EX_ready_i = ($urandom_range(0, 4) != 0);
        WB_privDone_i = ($urandom_range(0, 3) == 0);
    endtask

    initial begin
        m_state = 0; m_valid = 2'b00; m_ds = 2'b00; m_pay = '0;
        clear_in();
        rst = 1'b1;
        @(negedge clk);
        step();
        step();

        // Reset mid-stream with a valid pair present.
        rst = 1'b0; IQ_supplyValid = 2'b11;
        step();
        rst = 1'b1;
        #1 chk("rst_mode", PW'(ID_upDateMode_o), PW'(2'b00));
        step();
        chk("rst_valid", PW'(ID_valid_o), PW'(2'b00));
        rst = 1'b0;

        // Independent ALU pair.
        clear_in(); IQ_supplyValid = 2'b11;
        DEC_wen_p = 2'b01; DEC_wdst_p = {5'd0, 5'd3};
        DEC_ren_p = 4'b1100; DEC_rsrc_p = {5'd5, 5'd4, 10'd0};
        #1 chk("alu_mode", PW'(ID_upDateMode_o), PW'(2'b11));
        step();
        chk("alu_valid", PW'(ID_valid_o), PW'(2'b11));
        chk("alu_pc", PW'(ID_VAddr_p), PW'(64'h8000_0004_8000_0000));

        // RAW on r8, then the same with r0 as destination.
        DEC_wdst_p = {5'd0, 5'd8}; DEC_rsrc_p = {5'd5, 5'd8, 10'd0};
        #1 chk("raw_mode", PW'(ID_upDateMode_o), PW'(2'b01));
        step();
        DEC_wdst_p = '0; DEC_rsrc_p = {5'd5, 5'd0, 10'd0};
        #1 chk("raw_r0_mode", PW'(ID_upDateMode_o), PW'(2'b11));
        step();

        // Branch alone, two empty cycles, then the delay slot arrives.
        clear_in(); IQ_supplyValid = 2'b01; DEC_isBranch_p = 2'b01;
        #1 chk("br_mode", PW'(ID_upDateMode_o), PW'(2'b01));
        step();
        clear_in();
        step();
        step();
        IQ_supplyValid = 2'b11;
        step();
        chk("ds_flag", PW'(ID_isDelaySlot_o[0]), PW'(1'b1));

        // Privileged instruction serialises until it retires.
        clear_in(); IQ_supplyValid = 2'b11; DEC_isPriv_p = 2'b01;
        #1 chk("priv_mode", PW'(ID_upDateMode_o), PW'(2'b01));
        step();
        DEC_isPriv_p = 2'b00;
        for (int c = 0; c < 3; c++) begin
            #1 chk("serial_mode", PW'(ID_upDateMode_o), PW'(2'b00));
            step();
        end
        WB_privDone_i = 1'b1;
        step();
        WB_privDone_i = 1'b0;
        #1 chk("resume_mode", PW'(ID_upDateMode_o), PW'(2'b11));
        step();
        DEC_isPriv_p = 2'b01;
        step();
        DEC_isPriv_p = 2'b00; SBA_flush_w_i = 1'b1;
        step();
        SBA_flush_w_i = 1'b0;
        #1 chk("flush_serial", PW'(ID_upDateMode_o), PW'(2'b11));
        step();

        // Back-pressure, then a flush during the stall.
        IQ_VAddr_p = 64'h8000_0104_8000_0100;
        step();
        EX_ready_i = 1'b0; IQ_VAddr_p = 64'h8000_0204_8000_0200;
        step();
        chk("stall_hold", PW'(ID_VAddr_p), PW'(64'h8000_0104_8000_0100));
        CP0_excOccur_w_i = 1'b1;
        #1 chk("stall_mode", PW'(ID_upDateMode_o), PW'(2'b00));
        step();
        chk("stall_flush", PW'(ID_valid_o), PW'(2'b00));

        // Random traffic.
        for (int n = 0; n < 600; n++) begin
            rand_in();
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
